// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: frame geometry, counter widths
// and the frame sequencer state type.
package uart_rx_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned PRESC_W    = 6;
    localparam int unsigned EDGE_W     = 5;
    localparam int unsigned BIT_W      = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversample edge counter and bit index counter for one UART frame; both run
// while enabled and collapse to zero when disabled or cleared.
module uart_rx_edge_bit_counter
    import uart_rx_pkg::*;
#(
    parameter int unsigned PRESC_W = uart_rx_pkg::PRESC_W,
    parameter int unsigned EDGE_W  = uart_rx_pkg::EDGE_W,
    parameter int unsigned BIT_W   = uart_rx_pkg::BIT_W
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               enable,
    input  logic               clear,
    input  logic [PRESC_W-1:0] prescale_q,
    output logic [EDGE_W-1:0]  edge_cnt,
    output logic [BIT_W-1:0]   bit_cnt,
    output logic               bit_end
);

    logic [PRESC_W-1:0] edge_ext;

    assign edge_ext = PRESC_W'(edge_cnt);

    // Degenerate or oversized prescale values still end every bit so the
    // sequencer always makes progress.
    always_comb begin
        bit_end = 1'b0;
        if (prescale_q <= PRESC_W'(1)) begin
            bit_end = 1'b1;
        end else if (edge_cnt == '1) begin
            bit_end = 1'b1;
        end else if (edge_ext == prescale_q - PRESC_W'(1)) begin
            bit_end = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (!enable || clear) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (bit_end) begin
            edge_cnt <= '0;
            bit_cnt  <= bit_cnt + BIT_W'(1);
        end else begin
            edge_cnt <= edge_cnt + EDGE_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive frame sequencer: walks start/data/parity/stop bit periods,
// enables the sampler and checkers, and flags error-free frames.
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = uart_rx_pkg::DATA_WIDTH,
    parameter int unsigned PRESC_W    = uart_rx_pkg::PRESC_W,
    parameter int unsigned EDGE_W     = uart_rx_pkg::EDGE_W,
    parameter int unsigned BIT_W      = uart_rx_pkg::BIT_W
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX_IN,
    input  logic               PAR_EN,
    input  logic [PRESC_W-1:0] Prescale,
    input  logic               strt_glitch,
    input  logic               par_err,
    input  logic               stp_err,
    output logic               dat_samp_en,
    output logic               deser_en,
    output logic               strt_chk_en,
    output logic               par_chk_en,
    output logic               stp_chk_en,
    output logic               data_valid,
    output logic [EDGE_W-1:0]  edge_cnt,
    output logic [BIT_W-1:0]   bit_cnt
);

    state_t             state;
    state_t             state_next;
    logic [PRESC_W-1:0] prescale_q;
    logic               par_en_q;
    logic               bit_end;
    logic               frame_end;
    logic               relatch;
    logic               frame_ok;

    uart_rx_edge_bit_counter #(
        .PRESC_W (PRESC_W),
        .EDGE_W  (EDGE_W),
        .BIT_W   (BIT_W)
    ) u_counter (
        .CLK        (CLK),
        .RST        (RST),
        .enable     (state != ST_IDLE),
        .clear      (frame_end),
        .prescale_q (prescale_q),
        .edge_cnt   (edge_cnt),
        .bit_cnt    (bit_cnt),
        .bit_end    (bit_end)
    );

    always_comb begin
        state_next = state;
        frame_end  = 1'b0;
        relatch    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!RX_IN) begin
                    state_next = ST_START;
                    relatch    = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    if (strt_glitch) begin
                        state_next = ST_IDLE;
                        frame_end  = 1'b1;
                    end else begin
                        state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (bit_end && bit_cnt == BIT_W'(DATA_WIDTH)) begin
                    state_next = par_en_q ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    frame_end = 1'b1;
                    // A low line at the stop boundary is the next start bit.
                    if (!RX_IN) begin
                        state_next = ST_START;
                        relatch    = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign frame_ok = (state == ST_STOP) && bit_end && !stp_err && !(par_en_q && par_err);

    // Enables are loaded from the next state so they always mirror the state register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= ST_IDLE;
            prescale_q  <= PRESC_W'(8);
            par_en_q    <= 1'b0;
            dat_samp_en <= 1'b0;
            deser_en    <= 1'b0;
            strt_chk_en <= 1'b0;
            par_chk_en  <= 1'b0;
            stp_chk_en  <= 1'b0;
            data_valid  <= 1'b0;
        end else begin
            state       <= state_next;
            dat_samp_en <= (state_next != ST_IDLE);
            deser_en    <= (state_next == ST_DATA);
            strt_chk_en <= (state_next == ST_START);
            par_chk_en  <= (state_next == ST_PARITY);
            stp_chk_en  <= (state_next == ST_STOP);
            data_valid  <= frame_ok;
            if (relatch) begin
                prescale_q <= Prescale;
                par_en_q   <= PAR_EN;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Scoreboard bench for uart_rx_fsm: stimulus queues expected data_valid cycles,
// a monitor pops them as pulses appear and tallies per-enable activity.
module tb_uart_rx_fsm;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic       PAR_EN = 1'b0;
    logic [5:0] Prescale = 6'd8;
    logic       strt_glitch = 1'b0;
    logic       par_err = 1'b0;
    logic       stp_err = 1'b0;
    logic       dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid;
    logic [4:0] edge_cnt;
    logic [3:0] bit_cnt;

    int passed = 0;
    int total = 0;
    int cyc = 0;
    int dv_q[$];
    int samp_total = 0, deser_total = 0, strt_total = 0, par9_total = 0, dv_total = 0;
    int dv_prev = 0, dv_last = 0;

    uart_rx_fsm #(
        .DATA_WIDTH (8),
        .PRESC_W    (6),
        .EDGE_W     (5),
        .BIT_W      (4)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .PAR_EN      (PAR_EN),
        .Prescale    (Prescale),
        .strt_glitch (strt_glitch),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .dat_samp_en (dat_samp_en),
        .deser_en    (deser_en),
        .strt_chk_en (strt_chk_en),
        .par_chk_en  (par_chk_en),
        .stp_chk_en  (stp_chk_en),
        .data_valid  (data_valid),
        .edge_cnt    (edge_cnt),
        .bit_cnt     (bit_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int out_vec();
        return int'({dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en,
                     data_valid, edge_cnt, bit_cnt});
    endfunction

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            cyc++;
            if (dat_samp_en) samp_total++;
            if (deser_en) deser_total++;
            if (strt_chk_en) strt_total++;
            if (par_chk_en && bit_cnt == 4'd9) par9_total++;
            if (data_valid) begin
                dv_total++;
                dv_prev = dv_last;
                dv_last = cyc;
                if (dv_q.size() == 0) check("unexpected_data_valid", 1, 0);
                else check("data_valid_cycle", cyc, dv_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    task automatic bit_period(input logic b, input int p);
        RX_IN = b;
        repeat (p) @(negedge CLK);
    endtask

    // Called on a falling edge; returns at the falling edge inside the last stop cycle.
    task automatic send_frame(input logic [7:0] data, input int p, input bit par,
                              input bit bad_par, input bit bad_stop,
                              input int next_p, input bit next_par);
        int k;
        Prescale = 6'(p);
        PAR_EN   = par;
        k = cyc + 1;
        if (!bad_stop && !(par && bad_par)) dv_q.push_back(k + (10 + int'(par)) * p);
        bit_period(1'b0, p);
        for (int i = 0; i < 8; i++) begin
            if (i == 1) begin
                Prescale = 6'(next_p);
                PAR_EN   = next_par;
            end
            bit_period(data[i], p);
        end
        if (par) bit_period(^data, p);
        par_err = bad_par;
        stp_err = bad_stop;
        bit_period(1'b1, p);
    endtask

    initial begin
        int s0, d0, t0, p0, v0;

        repeat (3) @(negedge CLK);
        check("reset_outputs", out_vec(), 0);
        RST = 1'b1;
        idle(4);
        check("idle_outputs", out_vec(), 0);

        // 8x, no parity, good frame
        s0 = samp_total; d0 = deser_total; v0 = dv_total;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 8, 1'b0);
        idle(4);
        check("t1_deser_cycles", deser_total - d0, 64);
        check("t1_samp_cycles", samp_total - s0, 80);
        check("t1_dv_count", dv_total - v0, 1);

        // 8x, parity, parity error -> rejected
        s0 = samp_total; p0 = par9_total; v0 = dv_total;
        send_frame(8'h3C, 8, 1'b1, 1'b1, 1'b0, 8, 1'b1);
        idle(4);
        check("t2_parity_bit9_cycles", par9_total - p0, 8);
        check("t2_samp_cycles", samp_total - s0, 88);
        check("t2_dv_count", dv_total - v0, 0);
        check("t2_back_idle", int'(dat_samp_en), 0);

        // par_err ignored without parity; stop error rejects
        v0 = dv_total;
        send_frame(8'h11, 8, 1'b0, 1'b1, 1'b0, 8, 1'b0);
        idle(4);
        check("t2b_par_err_ignored", dv_total - v0, 1);
        v0 = dv_total;
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 8, 1'b0);
        idle(4);
        check("t2c_stop_err_rejected", dv_total - v0, 0);
        stp_err = 1'b0; par_err = 1'b0;

        // start glitch at edge 7
        s0 = samp_total; d0 = deser_total; t0 = strt_total;
        Prescale = 6'd8; PAR_EN = 1'b0;
        RX_IN = 1'b0;
        repeat (2) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (6) @(negedge CLK);
        check("t3_edge_at_glitch", int'(edge_cnt), 7);
        strt_glitch = 1'b1;
        @(negedge CLK);
        strt_glitch = 1'b0;
        idle(4);
        check("t3_strt_cycles", strt_total - t0, 8);
        check("t3_deser_cycles", deser_total - d0, 0);
        check("t3_samp_cycles", samp_total - s0, 8);

        // 16x with parity, back-to-back
        s0 = samp_total; t0 = strt_total; v0 = dv_total;
        send_frame(8'h5A, 16, 1'b1, 1'b0, 1'b0, 16, 1'b1);
        send_frame(8'hC3, 16, 1'b1, 1'b0, 1'b0, 16, 1'b1);
        idle(4);
        check("t4_dv_count", dv_total - v0, 2);
        check("t4_dv_spacing", dv_last - dv_prev, 176);
        check("t4_samp_cycles", samp_total - s0, 352);
        check("t4_strt_cycles", strt_total - t0, 32);

        // config change mid-frame only affects the next frame
        s0 = samp_total;
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 32, 1'b1);
        idle(4);
        check("t5_old_cfg_samp", samp_total - s0, 80);
        s0 = samp_total; p0 = par9_total;
        send_frame(8'h7E, 32, 1'b1, 1'b0, 1'b0, 32, 1'b1);
        idle(4);
        check("t5_new_cfg_samp", samp_total - s0, 352);
        check("t5_new_cfg_parity", par9_total - p0, 32);

        // reset in DATA at edge 5
        v0 = dv_total;
        Prescale = 6'd8; PAR_EN = 1'b0;
        RX_IN = 1'b0;
        repeat (8) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (6) @(negedge CLK);
        check("t6_edge_before_reset", int'(edge_cnt), 5);
        check("t6_deser_before_reset", int'(deser_en), 1);
        RST = 1'b0;
        #1;
        check("t6_outputs_in_reset", out_vec(), 0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        idle(20);
        check("t6_idle_after_reset", out_vec(), 0);
        check("t6_no_dv", dv_total - v0, 0);

        for (int i = 0; i < 50 && dv_q.size() != 0; i++) @(negedge CLK);
        check("scoreboard_drained", dv_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
